// File: rtl/mskaes_rcon_seq.sv
// Masked AES round-constant sequencer: AES-128/192/256, forward/backward stepping, d-share output.
// Optional macro MSKAES_RCON_SEQ_RANDOM_SHARE_EN adds input rnd for randomised output sharing.
module mskaes_rcon_seq #(
    parameter int unsigned d = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       key_size,
    input  logic             dir,
    input  logic             update,
    input  logic             mask_rcon,
`ifdef MSKAES_RCON_SEQ_RANDOM_SHARE_EN
    input  logic [8*(d-1)-1:0] rnd,
`endif
    output logic [8*d-1:0]   sh_rcon,
    output logic [3:0]       rcon_idx,
    output logic             last,
    output logic             overrun
);

    typedef enum logic [1:0] {
        KS_128 = 2'd0,
        KS_192 = 2'd1,
        KS_256 = 2'd2,
        KS_RSV = 2'd3
    } ks_e;

    logic [7:0] rcon_q, rcon_d;
    logic [3:0] idx_q, idx_d;
    ks_e        ks_q, ks_d;
    logic       dir_q, dir_d;
    logic       overrun_q, overrun_d;

    logic [3:0] last_idx;
    logic [7:0] rcon_fwd, rcon_bwd, rcon_init;
    logic [7:0] out_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            rcon_q    <= 8'h01;
            idx_q     <= '0;
            ks_q      <= KS_128;
            dir_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rcon_q    <= rcon_d;
            idx_q     <= idx_d;
            ks_q      <= ks_d;
            dir_q     <= dir_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        case (ks_q)
            KS_192:  last_idx = 4'd7;
            KS_256:  last_idx = 4'd6;
            default: last_idx = 4'd9;
        endcase
    end

    assign last = (idx_q == last_idx);

    // xtime and its inverse over GF(2^8) with the AES polynomial
    assign rcon_fwd = rcon_q[7] ? ((rcon_q << 1) ^ 8'h1B) : (rcon_q << 1);
    assign rcon_bwd = rcon_q[0] ? (((rcon_q ^ 8'h1B) >> 1) | 8'h80) : (rcon_q >> 1);

    always_comb begin
        rcon_init = 8'h01;
        if (dir) begin
            case (key_size)
                KS_192:  rcon_init = 8'h80;
                KS_256:  rcon_init = 8'h40;
                default: rcon_init = 8'h36;
            endcase
        end
    end

    always_comb begin
        rcon_d    = rcon_q;
        idx_d     = idx_q;
        ks_d      = ks_q;
        dir_d     = dir_q;
        overrun_d = overrun_q;
        if (start) begin
            ks_d      = (key_size == KS_RSV) ? KS_128 : ks_e'(key_size);
            dir_d     = dir;
            idx_d     = '0;
            overrun_d = 1'b0;
            rcon_d    = rcon_init;
        end else if (update) begin
            if (last) begin
                overrun_d = 1'b1;
            end else begin
                idx_d  = idx_q + 4'd1;
                rcon_d = dir_q ? rcon_bwd : rcon_fwd;
            end
        end
    end

    assign out_val  = rcon_q & {8{mask_rcon}};
    assign rcon_idx = idx_q;
    assign overrun  = overrun_q;

    always_comb begin
        sh_rcon = '0;
        for (int unsigned i = 0; i < 8; i++) begin
`ifdef MSKAES_RCON_SEQ_RANDOM_SHARE_EN
            // Mask gate zeroes every share, so rnd never leaks onto the bus while gated
            if (mask_rcon) begin
                sh_rcon[d*i] = out_val[i] ^ (^rnd[(d-1)*i +: (d-1)]);
                for (int unsigned j = 1; j < d; j++) begin
                    sh_rcon[d*i+j] = rnd[(d-1)*i + j - 1];
                end
            end
`else
            sh_rcon[d*i] = out_val[i];
`endif
        end
    end

endmodule

// File: tb/tb_mskaes_rcon_seq.sv
// Directed self-checking bench for mskaes_rcon_seq; covers both sharing builds.
module tb_mskaes_rcon_seq;

`ifdef MSKAES_RCON_SEQ_RANDOM_SHARE_EN
    localparam int unsigned D = 3;
`else
    localparam int unsigned D = 2;
`endif
    localparam int unsigned W = 8 * D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   key_size = 2'd0;
    logic         dir = 1'b0;
    logic         update = 1'b0;
    logic         mask_rcon = 1'b1;
`ifdef MSKAES_RCON_SEQ_RANDOM_SHARE_EN
    logic [8*(D-1)-1:0] rnd = '0;
`endif
    logic [W-1:0] sh_rcon;
    logic [3:0]   rcon_idx;
    logic         last;
    logic         overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    mskaes_rcon_seq #(.d(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_size  (key_size),
        .dir       (dir),
        .update    (update),
        .mask_rcon (mask_rcon),
`ifdef MSKAES_RCON_SEQ_RANDOM_SHARE_EN
        .rnd       (rnd),
`endif
        .sh_rcon   (sh_rcon),
        .rcon_idx  (rcon_idx),
        .last      (last),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] unshare(input logic [W-1:0] s);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < int'(D); j++)
                v[i] = v[i] ^ s[D*i+j];
        return v;
    endfunction

    task automatic check_out(input string tag, input logic [7:0] exp);
        logic [W-1:0] ev;
`ifdef MSKAES_RCON_SEQ_RANDOM_SHARE_EN
        logic [8*(D-1)-1:0] g;
        rnd = (8*(D-1))'($urandom);
        #1;
        g = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 1; j < int'(D); j++)
                g[(D-1)*i+j-1] = sh_rcon[D*i+j];
        check({tag, "/rnd"}, 32'(g), 32'(rnd));
`endif
        check({tag, "/val"}, 32'(unshare(sh_rcon)), 32'(exp));
`ifndef MSKAES_RCON_SEQ_RANDOM_SHARE_EN
        ev = '0;
        for (int i = 0; i < 8; i++) ev[D*i] = exp[i];
        check({tag, "/vec"}, 32'(sh_rcon), 32'(ev));
`endif
        mask_rcon = 1'b0;
        #1;
        check({tag, "/gated"}, 32'(sh_rcon), 32'h0);
        mask_rcon = 1'b1;
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] r, input int idx,
                               input logic l, input logic ov);
        check_out(tag, r);
        check({tag, "/idx"}, 32'(rcon_idx), 32'(idx));
        check({tag, "/last"}, 32'(last), 32'(l));
        check({tag, "/ovr"}, 32'(overrun), 32'(ov));
    endtask

    // start, then walk the whole sequence, then overrun once; inputs toggled mid-run must not matter
    task automatic run_seq(input logic [1:0] ks, input logic dr, input int n, input string nm);
        logic [7:0] e;
        key_size = ks;
        dir      = dr;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        key_size = ks + 2'd1;
        dir      = ~dr;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                update = 1'b1;
                tick();
                update = 1'b0;
            end
            e = dr ? fwd[n-1-k] : fwd[k];
            check_state($sformatf("%s/s%0d", nm, k), e, k, (k == n-1), 1'b0);
        end
        e = dr ? fwd[0] : fwd[n-1];
        update = 1'b1;
        tick();
        update = 1'b0;
        check_state({nm, "/over"}, e, n-1, 1'b1, 1'b1);
        tick();
        check({nm, "/ovr_hold"}, 32'(overrun), 32'h1);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_state("reset", 8'h01, 0, 1'b0, 1'b0);

        run_seq(2'd0, 1'b0, 10, "k128f");
        run_seq(2'd0, 1'b1, 10, "k128b");
        run_seq(2'd1, 1'b1, 8,  "k192b");
        run_seq(2'd1, 1'b0, 8,  "k192f");
        run_seq(2'd2, 1'b0, 7,  "k256f");
        run_seq(2'd2, 1'b1, 7,  "k256b");
        run_seq(2'd3, 1'b1, 10, "krsvb");

        // start wins over a simultaneous update
        key_size = 2'd0;
        dir      = 1'b0;
        start    = 1'b1;
        update   = 1'b1;
        tick();
        start    = 1'b0;
        update   = 1'b0;
        check_state("st_upd", 8'h01, 0, 1'b0, 1'b0);

        run_seq(2'd2, 1'b0, 7, "pre_rst");
        rst      = 1'b1;
        start    = 1'b1;
        update   = 1'b1;
        key_size = 2'd2;
        dir      = 1'b1;
        tick();
        rst      = 1'b0;
        start    = 1'b0;
        update   = 1'b0;
        check_state("mid_rst", 8'h01, 0, 1'b0, 1'b0);
        for (int k = 1; k < 10; k++) begin
            update = 1'b1;
            tick();
            update = 1'b0;
            check_state($sformatf("post_rst/s%0d", k), fwd[k], k, (k == 9), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
